// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix command decoder slice.
// Holds the row width, command opcodes, identity row constants, the decoder
// state encoding and a helper telling which states accept a FIFO entry.
package matrix_pkg;

  localparam int ROW_W = 128;

  localparam logic [ROW_W-1:0] ROW_ZERO = {ROW_W{1'b0}};

  // Opcodes carried on cmd_op; 3'd7 is unassigned and behaves as NOP.
  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_MODE    = 3'd1;
  localparam logic [2:0] OP_LOAD_ID = 3'd2;
  localparam logic [2:0] OP_LOAD    = 3'd3;
  localparam logic [2:0] OP_PUSH    = 3'd4;
  localparam logic [2:0] OP_POP     = 3'd5;
  localparam logic [2:0] OP_MULT    = 3'd6;

  // Identity matrix rows, element 0 in the most significant word.
  localparam logic [ROW_W-1:0] IDENT_ROW0 = 128'h3F800000_00000000_00000000_00000000;
  localparam logic [ROW_W-1:0] IDENT_ROW1 = 128'h00000000_3F800000_00000000_00000000;
  localparam logic [ROW_W-1:0] IDENT_ROW2 = 128'h00000000_00000000_3F800000_00000000;
  localparam logic [ROW_W-1:0] IDENT_ROW3 = 128'h00000000_00000000_00000000_3F800000;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_LOAD1  = 4'd1,
    ST_LOAD2  = 4'd2,
    ST_LOAD3  = 4'd3,
    ST_MCOL1  = 4'd4,
    ST_MCOL2  = 4'd5,
    ST_MCOL3  = 4'd6,
    ST_MWAIT  = 4'd7,
    ST_MWRITE = 4'd8
  } dec_state_e;

  // States in which the decoder pops a FIFO entry whenever one is offered.
  function automatic logic takes_row(input dec_state_e st);
    case (st)
      ST_IDLE, ST_LOAD1, ST_LOAD2, ST_LOAD3,
      ST_MCOL1, ST_MCOL2, ST_MCOL3: takes_row = 1'b1;
      default:                      takes_row = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/matrix_cmd_decoder_if.sv
// Command FIFO read port between the command FIFO (master) and the decoder
// (slave).
//   cmd_valid : FIFO not empty (for LOAD: all four rows present)
//   cmd_op    : opcode of the head entry
//   cmd_data  : row payload of the head entry
//   cmd_rd    : decoder pops the head entry this cycle
interface matrix_cmd_decoder_if;
  import matrix_pkg::*;

  logic             cmd_valid;
  logic [2:0]       cmd_op;
  logic [ROW_W-1:0] cmd_data;
  logic             cmd_rd;

  modport master (output cmd_valid, output cmd_op, output cmd_data, input cmd_rd);
  modport slave  (input cmd_valid, input cmd_op, input cmd_data, output cmd_rd);
endinterface

// File: rtl/matrix_depth_tracker.sv
// Per-mode stack depth counters for the matrix stack controller.
// Answers whether a push or pop is legal in the current mode, applies legal
// requests and raises sticky overflow/underflow flags on illegal ones.
//   clk, reset       : clock, synchronous active-high reset
//   mode             : 0 modelview, 1 projection
//   push_req/pop_req : single-cycle requests for the command being consumed
//   push_ok/pop_ok   : legality of a push/pop in the current mode
//   err_overflow/err_underflow : sticky, cleared only by reset
module matrix_depth_tracker #(
  parameter int MAX_DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic mode,
  input  logic push_req,
  input  logic pop_req,
  output logic push_ok,
  output logic pop_ok,
  output logic err_overflow,
  output logic err_underflow
);
  localparam int DW = $clog2(MAX_DEPTH + 1);

  logic [DW-1:0] depth_mv_r;
  logic [DW-1:0] depth_pj_r;
  logic [DW-1:0] depth_cur_s;

  // Select the counter of the active mode and derive legality from it.
  always_comb begin
    depth_cur_s = depth_mv_r;
    if (mode) begin
      depth_cur_s = depth_pj_r;
    end else begin
      depth_cur_s = depth_mv_r;
    end
    push_ok = (depth_cur_s < DW'(MAX_DEPTH));
    pop_ok  = (depth_cur_s > DW'(1));
  end

  // Counter update and sticky error flags; a stack always holds at least one matrix.
  always_ff @(posedge clk) begin
    if (reset) begin
      depth_mv_r    <= DW'(1);
      depth_pj_r    <= DW'(1);
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else if (push_req) begin
      if (!push_ok) begin
        err_overflow <= 1'b1;
      end else if (mode) begin
        depth_pj_r <= depth_pj_r + DW'(1);
      end else begin
        depth_mv_r <= depth_mv_r + DW'(1);
      end
    end else if (pop_req) begin
      if (!pop_ok) begin
        err_underflow <= 1'b1;
      end else if (mode) begin
        depth_pj_r <= depth_pj_r - DW'(1);
      end else begin
        depth_mv_r <= depth_mv_r - DW'(1);
      end
    end
  end
endmodule

// File: rtl/matrix_cmd_decoder.sv
// Upstream command stage of the matrix stack controller.
// Pops commands from the command FIFO (show-ahead, cmd_rd consumes the head in
// the same cycle) and turns them into one-cycle controller strobes, sequences
// four-row LOAD streams, keeps the matrix_mode select and hands MULT to an
// external 4x4 multiplier via mul_start/mul_done.
//   clk, reset      : clock, synchronous active-high reset
//   cmd             : command FIFO read port (slave side)
//   fifo_full       : downstream stall, freezes the block
//   matrix_mode     : 0 modelview, 1 projection
//   pop_en/push_en/load_en/load_id_en/write_en : controller strobes
//   data_in         : LOAD row to the controller
//   write_in_0..3   : product rows to the controller, row 0 = top
//   peek_in_0..3    : current top matrix from the controller
//   mul_*           : multiplier operands, start pulse, done pulse, result
//   err_overflow/err_underflow : sticky stack errors
//   busy            : FSM not in IDLE
// FIFO contract: cmd_valid is only raised for a LOAD once all four of its rows
// are queued, because the controller consumes one row per cycle after load_en.
module matrix_cmd_decoder
  import matrix_pkg::*;
#(
  parameter int MAX_DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  matrix_cmd_decoder_if.slave cmd,
  input  logic             fifo_full,
  output logic             matrix_mode,
  output logic             pop_en,
  output logic             push_en,
  output logic             load_en,
  output logic             load_id_en,
  output logic [ROW_W-1:0] data_in,
  output logic             write_en,
  output logic [ROW_W-1:0] write_in_0,
  output logic [ROW_W-1:0] write_in_1,
  output logic [ROW_W-1:0] write_in_2,
  output logic [ROW_W-1:0] write_in_3,
  input  logic [ROW_W-1:0] peek_in_0,
  input  logic [ROW_W-1:0] peek_in_1,
  input  logic [ROW_W-1:0] peek_in_2,
  input  logic [ROW_W-1:0] peek_in_3,
  output logic             mul_start,
  output logic [ROW_W-1:0] mul_a_0,
  output logic [ROW_W-1:0] mul_a_1,
  output logic [ROW_W-1:0] mul_a_2,
  output logic [ROW_W-1:0] mul_a_3,
  output logic [ROW_W-1:0] mul_b_0,
  output logic [ROW_W-1:0] mul_b_1,
  output logic [ROW_W-1:0] mul_b_2,
  output logic [ROW_W-1:0] mul_b_3,
  input  logic             mul_done,
  input  logic [ROW_W-1:0] mul_res_0,
  input  logic [ROW_W-1:0] mul_res_1,
  input  logic [ROW_W-1:0] mul_res_2,
  input  logic [ROW_W-1:0] mul_res_3,
  output logic             err_overflow,
  output logic             err_underflow,
  output logic             busy
);
  dec_state_e state_r;
  logic       take_s;
  logic       push_req_s;
  logic       pop_req_s;
  logic       push_ok_s;
  logic       pop_ok_s;
  logic       drain_r;     // current LOAD overflowed: rows are popped and discarded
  logic       mul_pend_r;  // mul_done arrived while stalled

  // Pop the FIFO head whenever the FSM can accept an entry and nothing stalls.
  always_comb begin
    take_s = 1'b0;
    if (!reset && !fifo_full && cmd.cmd_valid && takes_row(state_r)) begin
      take_s = 1'b1;
    end else begin
      take_s = 1'b0;
    end
  end

  assign cmd.cmd_rd = take_s;
  assign busy       = (state_r != ST_IDLE);

  // Depth requests for the command consumed in IDLE; LOAD pushes a new matrix.
  always_comb begin
    push_req_s = 1'b0;
    pop_req_s  = 1'b0;
    if (take_s && (state_r == ST_IDLE)) begin
      push_req_s = (cmd.cmd_op == OP_PUSH) || (cmd.cmd_op == OP_LOAD);
      pop_req_s  = (cmd.cmd_op == OP_POP);
    end else begin
      push_req_s = 1'b0;
      pop_req_s  = 1'b0;
    end
  end

  matrix_depth_tracker #(
    .MAX_DEPTH (MAX_DEPTH)
  ) u_depth (
    .clk           (clk),
    .reset         (reset),
    .mode          (matrix_mode),
    .push_req      (push_req_s),
    .pop_req       (pop_req_s),
    .push_ok       (push_ok_s),
    .pop_ok        (pop_ok_s),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow)
  );

  // Decoder FSM with registered strobes, LOAD row stream and MULT handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      drain_r     <= 1'b0;
      mul_pend_r  <= 1'b0;
      matrix_mode <= 1'b0;
      pop_en      <= 1'b0;
      push_en     <= 1'b0;
      load_en     <= 1'b0;
      load_id_en  <= 1'b0;
      write_en    <= 1'b0;
      mul_start   <= 1'b0;
      data_in     <= ROW_ZERO;
      write_in_0  <= ROW_ZERO;
      write_in_1  <= ROW_ZERO;
      write_in_2  <= ROW_ZERO;
      write_in_3  <= ROW_ZERO;
      mul_a_0     <= ROW_ZERO;
      mul_a_1     <= ROW_ZERO;
      mul_a_2     <= ROW_ZERO;
      mul_a_3     <= ROW_ZERO;
      mul_b_0     <= ROW_ZERO;
      mul_b_1     <= ROW_ZERO;
      mul_b_2     <= ROW_ZERO;
      mul_b_3     <= ROW_ZERO;
    end else if (fifo_full) begin
      pop_en     <= 1'b0;
      push_en    <= 1'b0;
      load_en    <= 1'b0;
      load_id_en <= 1'b0;
      write_en   <= 1'b0;
      mul_start  <= 1'b0;
      // The multiplier shows its result for one cycle only, so the rows are
      // kept together with the pending bit and written once the stall clears.
      if ((state_r == ST_MWAIT) && mul_done) begin
        mul_pend_r <= 1'b1;
        write_in_0 <= mul_res_0;
        write_in_1 <= mul_res_1;
        write_in_2 <= mul_res_2;
        write_in_3 <= mul_res_3;
      end
    end else begin
      pop_en     <= 1'b0;
      push_en    <= 1'b0;
      load_en    <= 1'b0;
      load_id_en <= 1'b0;
      write_en   <= 1'b0;
      mul_start  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (take_s) begin
            case (cmd.cmd_op)
              OP_MODE:    matrix_mode <= cmd.cmd_data[0];
              OP_LOAD_ID: load_id_en  <= 1'b1;
              OP_PUSH:    push_en     <= push_ok_s;
              OP_POP:     pop_en      <= pop_ok_s;
              OP_LOAD: begin
                load_en <= push_ok_s;
                drain_r <= ~push_ok_s;
                if (push_ok_s) begin
                  data_in <= cmd.cmd_data;
                end
                state_r <= ST_LOAD1;
              end
              OP_MULT: begin
                mul_b_0 <= cmd.cmd_data;
                mul_a_0 <= peek_in_0;
                mul_a_1 <= peek_in_1;
                mul_a_2 <= peek_in_2;
                mul_a_3 <= peek_in_3;
                state_r <= ST_MCOL1;
              end
              default: matrix_mode <= matrix_mode;  // NOP and opcode 7
            endcase
          end
        end
        ST_LOAD1, ST_LOAD2, ST_LOAD3: begin
          if (take_s) begin
            if (!drain_r) begin
              data_in <= cmd.cmd_data;
            end
            case (state_r)
              ST_LOAD1: state_r <= ST_LOAD2;
              ST_LOAD2: state_r <= ST_LOAD3;
              default:  state_r <= ST_IDLE;
            endcase
          end
        end
        ST_MCOL1: begin
          if (take_s) begin
            mul_b_1 <= cmd.cmd_data;
            state_r <= ST_MCOL2;
          end
        end
        ST_MCOL2: begin
          if (take_s) begin
            mul_b_2 <= cmd.cmd_data;
            state_r <= ST_MCOL3;
          end
        end
        ST_MCOL3: begin
          if (take_s) begin
            mul_b_3   <= cmd.cmd_data;
            mul_start <= 1'b1;
            state_r   <= ST_MWAIT;
          end
        end
        ST_MWAIT: begin
          if (mul_pend_r) begin
            mul_pend_r <= 1'b0;
            write_en   <= 1'b1;
            state_r    <= ST_MWRITE;
          end else if (mul_done) begin
            write_in_0 <= mul_res_0;
            write_in_1 <= mul_res_1;
            write_in_2 <= mul_res_2;
            write_in_3 <= mul_res_3;
            write_en   <= 1'b1;
            state_r    <= ST_MWRITE;
          end
        end
        ST_MWRITE: state_r <= ST_IDLE;
        default:   state_r <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_matrix_cmd_decoder.sv
// Self-checking bench for matrix_cmd_decoder: a show-ahead FIFO model feeds
// commands, a reference model predicts each beat's response into a scoreboard
// queue, and a monitor pops and compares when the decoder responds.
module tb_matrix_cmd_decoder;
  import matrix_pkg::*;

  localparam int MAXD = 2;
  localparam logic [4:0] S_LID = 5'b10000;
  localparam logic [4:0] S_LD  = 5'b01000;
  localparam logic [4:0] S_PU  = 5'b00100;
  localparam logic [4:0] S_PO  = 5'b00010;
  localparam logic [4:0] S_MS  = 5'b00001;

  localparam logic [ROW_W-1:0] P0 = 128'h3B4CCCCD_00000000_00000000_BF800000;
  localparam logic [ROW_W-1:0] P1 = 128'h00000000_3C23D70A_00000000_00000000;
  localparam logic [ROW_W-1:0] P2 = 128'h00000000_00000000_BF800000_C0000000;
  localparam logic [ROW_W-1:0] P3 = 128'h00000000_00000000_BF800000_00000000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, fifo_full, matrix_mode, pop_en, push_en, load_en, load_id_en;
  logic write_en, mul_start, mul_done, err_overflow, err_underflow, busy;
  logic [ROW_W-1:0] data_in, write_in_0, write_in_1, write_in_2, write_in_3;
  logic [ROW_W-1:0] peek_in_0, peek_in_1, peek_in_2, peek_in_3;
  logic [ROW_W-1:0] mul_a_0, mul_a_1, mul_a_2, mul_a_3;
  logic [ROW_W-1:0] mul_b_0, mul_b_1, mul_b_2, mul_b_3;
  logic [ROW_W-1:0] mul_res_0, mul_res_1, mul_res_2, mul_res_3;

  matrix_cmd_decoder_if cif ();

  matrix_cmd_decoder #(.MAX_DEPTH(MAXD)) dut (
    .clk(clk), .reset(reset), .cmd(cif.slave), .fifo_full(fifo_full),
    .matrix_mode(matrix_mode), .pop_en(pop_en), .push_en(push_en),
    .load_en(load_en), .load_id_en(load_id_en), .data_in(data_in),
    .write_en(write_en), .write_in_0(write_in_0), .write_in_1(write_in_1),
    .write_in_2(write_in_2), .write_in_3(write_in_3),
    .peek_in_0(peek_in_0), .peek_in_1(peek_in_1), .peek_in_2(peek_in_2), .peek_in_3(peek_in_3),
    .mul_start(mul_start), .mul_a_0(mul_a_0), .mul_a_1(mul_a_1), .mul_a_2(mul_a_2), .mul_a_3(mul_a_3),
    .mul_b_0(mul_b_0), .mul_b_1(mul_b_1), .mul_b_2(mul_b_2), .mul_b_3(mul_b_3),
    .mul_done(mul_done), .mul_res_0(mul_res_0), .mul_res_1(mul_res_1),
    .mul_res_2(mul_res_2), .mul_res_3(mul_res_3),
    .err_overflow(err_overflow), .err_underflow(err_underflow), .busy(busy)
  );

  typedef struct { logic [2:0] op; logic [ROW_W-1:0] data; } cmd_t;
  typedef struct { logic [4:0] strb; logic [ROW_W-1:0] data; logic mode; } exp_t;
  typedef struct { logic [ROW_W-1:0] r0, r1, r2, r3; } wr_t;

  cmd_t cmd_q [$];
  exp_t exp_q [$];
  wr_t  wr_q  [$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int               m_depth [2];
  logic             m_mode;
  logic             m_ovf, m_unf;
  logic [ROW_W-1:0] m_data_in;
  bit               mul_en;

  task automatic check(input string tag, input logic [ROW_W-1:0] got, input logic [ROW_W-1:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic model_reset();
    m_depth[0] = 1; m_depth[1] = 1;
    m_mode = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    m_data_in = ROW_ZERO;
  endtask

  task automatic push_beat(input logic [2:0] op, input logic [ROW_W-1:0] d, input logic [4:0] strb);
    cmd_t c;
    exp_t e;
    c.op = op; c.data = d;
    e.strb = strb; e.data = m_data_in; e.mode = m_mode;
    cmd_q.push_back(c);
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [2:0] op, input logic [ROW_W-1:0] d);
    logic [4:0] strb;
    strb = 5'b00000;
    case (op)
      OP_MODE:    m_mode = d[0];
      OP_LOAD_ID: strb = S_LID;
      OP_PUSH: if (m_depth[m_mode] < MAXD) begin strb = S_PU; m_depth[m_mode]++; end else m_ovf = 1'b1;
      OP_POP:  if (m_depth[m_mode] > 1) begin strb = S_PO; m_depth[m_mode]--; end else m_unf = 1'b1;
      default: strb = 5'b00000;
    endcase
    push_beat(op, d, strb);
  endtask

  task automatic send_load(input logic [ROW_W-1:0] r0, r1, r2, r3);
    logic [ROW_W-1:0] rows [4];
    bit ok;
    rows[0] = r0; rows[1] = r1; rows[2] = r2; rows[3] = r3;
    ok = (m_depth[m_mode] < MAXD);
    if (ok) m_depth[m_mode]++; else m_ovf = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (ok) m_data_in = rows[i];
      push_beat(OP_LOAD, rows[i], (ok && i == 0) ? S_LD : 5'b00000);
    end
  endtask

  // B = identity, so the expected product equals the peek snapshot A.
  task automatic send_mult(input bit expect_wr);
    wr_t w;
    push_beat(OP_MULT, IDENT_ROW0, 5'b00000);
    push_beat(OP_MULT, IDENT_ROW1, 5'b00000);
    push_beat(OP_MULT, IDENT_ROW2, 5'b00000);
    push_beat(OP_MULT, IDENT_ROW3, S_MS);
    if (expect_wr) begin
      w.r0 = P0; w.r1 = P1; w.r2 = P2; w.r3 = P3;
      wr_q.push_back(w);
    end
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((cmd_q.size() != 0 || exp_q.size() != 0 || wr_q.size() != 0 || busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check(tag, ROW_W'(cmd_q.size() + exp_q.size() + wr_q.size()), ROW_W'(0));
  endtask

  // Show-ahead FIFO model: pops the head after a cycle with cmd_rd high.
  initial begin
    bit rd_now;
    cif.cmd_valid = 1'b0; cif.cmd_op = OP_NOP; cif.cmd_data = ROW_ZERO;
    forever begin
      @(negedge clk);
      rd_now = cif.cmd_rd;
      @(posedge clk);
      #1;
      if (rd_now && cmd_q.size() > 0) void'(cmd_q.pop_front());
      cif.cmd_valid = (cmd_q.size() > 0);
      if (cmd_q.size() > 0) begin
        cif.cmd_op = cmd_q[0].op; cif.cmd_data = cmd_q[0].data;
      end else begin
        cif.cmd_op = OP_NOP; cif.cmd_data = ROW_ZERO;
      end
    end
  end

  // Monitor: each consumed beat gets its response compared the next cycle.
  initial begin
    bit rd_prev;
    logic [4:0] strb;
    exp_t e;
    wr_t w;
    rd_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        rd_prev = 1'b0;
      end else begin
        strb = {load_id_en, load_en, push_en, pop_en, mul_start};
        if (rd_prev) begin
          if (exp_q.size() == 0) begin
            check("rd_without_cmd", ROW_W'(exp_q.size()), ROW_W'(1));
          end else begin
            e = exp_q.pop_front();
            check("beat_strobes", ROW_W'(strb), ROW_W'(e.strb));
            check("beat_data_in", data_in, e.data);
            check("beat_mode", ROW_W'(matrix_mode), ROW_W'(e.mode));
          end
        end else begin
          check("idle_strobes", ROW_W'(strb), ROW_W'(0));
        end
        if (write_en) begin
          if (wr_q.size() == 0) begin
            check("write_unexpected", ROW_W'(wr_q.size()), ROW_W'(1));
          end else begin
            w = wr_q.pop_front();
            check("write_in_0", write_in_0, w.r0);
            check("write_in_1", write_in_1, w.r1);
            check("write_in_2", write_in_2, w.r2);
            check("write_in_3", write_in_3, w.r3);
          end
        end
        rd_prev = cif.cmd_rd;
      end
    end
  end

  // Multiplier model: result = A*B, modelled for B = identity; done 5 cycles after start.
  initial begin
    logic [ROW_W-1:0] a0, a1, a2, a3;
    bit id_ok;
    mul_done = 1'b0;
    mul_res_0 = ROW_ZERO; mul_res_1 = ROW_ZERO; mul_res_2 = ROW_ZERO; mul_res_3 = ROW_ZERO;
    forever begin
      @(negedge clk);
      if (mul_start && !reset) begin
        check("mul_a_0", mul_a_0, P0);
        check("mul_b_3", mul_b_3, IDENT_ROW3);
        a0 = mul_a_0; a1 = mul_a_1; a2 = mul_a_2; a3 = mul_a_3;
        id_ok = (mul_b_0 == IDENT_ROW0) && (mul_b_1 == IDENT_ROW1) &&
                (mul_b_2 == IDENT_ROW2) && (mul_b_3 == IDENT_ROW3);
        if (mul_en) begin
          repeat (5) @(posedge clk);
          #1;
          mul_done = 1'b1;
          mul_res_0 = id_ok ? a0 : ROW_ZERO; mul_res_1 = id_ok ? a1 : ROW_ZERO;
          mul_res_2 = id_ok ? a2 : ROW_ZERO; mul_res_3 = id_ok ? a3 : ROW_ZERO;
          @(posedge clk);
          #1;
          mul_done = 1'b0;
        end
      end
    end
  end

  initial begin
    int n, run;
    reset = 1'b1; fifo_full = 1'b0; mul_en = 1'b1;
    peek_in_0 = P0; peek_in_1 = P1; peek_in_2 = P2; peek_in_3 = P3;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_rd", ROW_W'(cif.cmd_rd), ROW_W'(0));
    check("rst_mode", ROW_W'(matrix_mode), ROW_W'(0));
    check("rst_strobes", ROW_W'({pop_en, push_en, load_en, load_id_en, write_en, mul_start}), ROW_W'(0));
    check("rst_data_in", data_in, ROW_ZERO);
    check("rst_write_in_0", write_in_0, ROW_ZERO);
    check("rst_mul_a_0", mul_a_0, ROW_ZERO);
    check("rst_errors", ROW_W'({err_overflow, err_underflow}), ROW_W'(0));
    check("rst_busy", ROW_W'(busy), ROW_W'(0));
    @(posedge clk); #1 reset = 1'b0;

    // Depth limits in modelview, then underflow in projection.
    send(OP_PUSH, ROW_ZERO); send(OP_PUSH, ROW_ZERO);
    wait_drain("drain_push");
    check("err_overflow_push", ROW_W'(err_overflow), ROW_W'(m_ovf));
    check("err_underflow_clear", ROW_W'(err_underflow), ROW_W'(m_unf));
    send(OP_MODE, 128'd1); send(OP_POP, ROW_ZERO);
    wait_drain("drain_pop");
    check("err_underflow_pop", ROW_W'(err_underflow), ROW_W'(m_unf));
    send(OP_PUSH, ROW_ZERO); send(OP_POP, ROW_ZERO);
    send(OP_MODE, ROW_ZERO); send(OP_POP, ROW_ZERO);
    send(OP_NOP, ROW_ZERO); send(3'd7, ROW_ZERO);
    wait_drain("drain_misc");

    // Back-to-back LOAD, cmd_rd must stay high for exactly the four rows.
    send_load(128'h3F800000_00000000_00000000_00000000, 128'h00000000_3F800000_00000000_40A00000,
              128'h00000000_00000000_3F800000_C1200000, 128'h00000000_00000000_00000000_3F800000);
    n = 0;
    while (!cif.cmd_rd && n < 50) begin @(negedge clk); n++; end
    run = 0;
    while (cif.cmd_rd && run < 10) begin run++; @(negedge clk); end
    check("load_rd_run", ROW_W'(run), ROW_W'(4));
    wait_drain("drain_load");

    // LOAD at full depth: overflow, rows drained without strobes or data change.
    send_load(128'h11111111_0, 128'h22222222_0, 128'h33333333_0, 128'h44444444_0);
    wait_drain("drain_load_ovf");
    check("err_overflow_load", ROW_W'(err_overflow), ROW_W'(m_ovf));

    // LOAD in projection with a 3-cycle stall after row 1.
    send(OP_MODE, 128'd1);
    wait_drain("drain_mode1");
    send_load(128'hA0000000_0, 128'hA1111111_0, 128'hA2222222_0, 128'hA3333333_0);
    n = 0;
    while (!load_en && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1 fifo_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_cmd_rd", ROW_W'(cif.cmd_rd), ROW_W'(0));
      check("stall_data_in", data_in, 128'hA1111111_0);
    end
    @(posedge clk); #1 fifo_full = 1'b0;
    wait_drain("drain_stall");

    // MULT with identity B; multiplier answers after 5 cycles.
    send_mult(1'b1);
    wait_drain("drain_mult");

    // MODE changes then LOAD_ID sees mode 1.
    send(OP_MODE, ROW_ZERO); send(OP_MODE, 128'd1); send(OP_LOAD_ID, ROW_ZERO);
    wait_drain("drain_load_id");

    // Reset while waiting on a multiplier that never answers.
    mul_en = 1'b0;
    send_mult(1'b0);
    n = 0;
    while (!mul_start && n < 50) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    check("mwait_busy", ROW_W'(busy), ROW_W'(1));
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk);
    @(posedge clk); #1 reset = 1'b0;
    model_reset();
    mul_en = 1'b1;
    @(negedge clk);
    check("mid_rst_mode", ROW_W'(matrix_mode), ROW_W'(0));
    check("mid_rst_busy", ROW_W'(busy), ROW_W'(0));
    check("mid_rst_errors", ROW_W'({err_overflow, err_underflow}), ROW_W'(0));
    repeat (10) @(negedge clk);
    send(OP_PUSH, ROW_ZERO); send(OP_PUSH, ROW_ZERO);
    wait_drain("drain_post_rst");
    check("err_overflow_post_rst", ROW_W'(err_overflow), ROW_W'(m_ovf));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
